accel_spi_reader: RTL and testbench

//  SPI master that performs one burst register read from the accelerometer: sends a read

---
 rtl/accel_spi_pkg.sv | 38 +++
 rtl/spi_sck_gen.sv | 65 ++++++
 rtl/accel_spi_reader.sv | 209 ++++++++++++++++++++
 tb/tb_accel_spi_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_spi_pkg.sv
// -----------------------------------------------------------------------------
// accel_spi_pkg
// Shared definitions for the accelerometer SPI burst reader:
//   state_t       FSM state encoding (IDLE/SETUP/XFER/HOLD/DONE)
//   CMD_*         bit positions inside the SPI command byte
//   SPI_CMD_BITS  length of the command phase in SCK periods
//   total_bits()  command + data length of one burst in SCK periods
//   read_cmd()    assembles the read command byte from an address
// -----------------------------------------------------------------------------
package accel_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

  localparam int CMD_READ_BIT = 7;
  localparam int CMD_MB_BIT   = 6;
  localparam int SPI_CMD_BITS = 8;

  function automatic int total_bits(input int num_bytes);
    return SPI_CMD_BITS + 8 * num_bytes;
  endfunction

  // Read command: read flag, multi-byte (auto-increment) flag, 6-bit address.
  function automatic logic [7:0] read_cmd(input logic [5:0] addr, input logic multi);
    logic [7:0] cmd;
    cmd               = '0;
    cmd[CMD_READ_BIT] = 1'b1;
    cmd[CMD_MB_BIT]   = multi;
    cmd[5:0]          = addr;
    return cmd;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen
// SCK generator for SPI mode 3. Counts CLK_DIV clk cycles per SCK half-period
// while enabled and reports the end of each half-period with one-cycle strobes.
// While disabled the counter is cleared and SCK rests high.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   en       in   generator running (SETUP/XFER/HOLD)
//   run      in   allow a falling SCK edge at the end of the current high half
//   sck      out  SCK level, idle high
//   tick     out  last clk cycle of the current half-period
//   rise     out  SCK goes high at this clk edge
//   fall     out  SCK goes low at this clk edge
//   high_end out  a high half-period ends at this clk edge (falls or not)
// -----------------------------------------------------------------------------
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic run,
  output logic sck,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic high_end
);

  localparam int                 CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick     = en && (cnt == CNT_LAST);
  assign rise     = tick && !sck;
  assign fall     = tick && sck && run;
  assign high_end = tick && sck;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b1;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b1;
    end else begin
      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (rise) begin
        sck <= 1'b1;
      end else if (fall) begin
        sck <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/accel_spi_reader.sv
// -----------------------------------------------------------------------------
// accel_spi_reader
// SPI mode-3 master performing one burst register read from the accelerometer:
// sends {read, MB, addr}, then clocks in NUM_BYTES data bytes, MSB first.
// start->done latency is 1 + CLK_DIV*(2*TOTAL_BITS+2) clk cycles.
//
// Parameters:
//   CLK_DIV    clk cycles per SCK half-period (>=1)
//   NUM_BYTES  data bytes per burst (1..8)
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   start  in   burst request, only looked at in IDLE
//   addr   in   first register address, captured when start is accepted
//   busy   out  burst in progress
//   done   out  one-cycle pulse; data valid from this cycle on
//   data   out  burst result, first received byte in the MSBs
//   SCK    out  SPI clock, idle high
//   MOSI   out  command out, MSB first
//   MISO   in   data in, MSB first
//   CS     out  active-low chip select
//
// Build option:
//   SPI_LATE_SAMPLE_EN  when defined, MISO is sampled at the end of each SCK
//                       high half-period instead of on the SCK rising edge,
//                       for slaves that update MISO on SCK rise.
// -----------------------------------------------------------------------------
module accel_spi_reader
  import accel_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int NUM_BYTES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [5:0]             addr,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] data,
  output logic                   SCK,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic                   CS
);

  localparam int               TOTAL_BITS = total_bits(NUM_BYTES);
  localparam int               DATA_W     = 8 * NUM_BYTES;
  localparam int               BIT_W      = $clog2(TOTAL_BITS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(TOTAL_BITS);
  localparam logic             MULTI      = (NUM_BYTES > 1) ? 1'b1 : 1'b0;

  state_t state;
  state_t state_next;

  logic              load;
  logic              finish;
  logic              sck_en;
  logic              sck_run;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              high_end;
  logic              last_bit;
  logic              tx_shift;
  logic              sample;
  logic [7:0]        cmd_word;
  logic [6:0]        tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BIT_W-1:0]  bit_cnt;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (sck_en),
    .run      (sck_run),
    .sck      (SCK),
    .tick     (tick),
    .rise     (rise),
    .fall     (fall),
    .high_end (high_end)
  );

  assign cmd_word = read_cmd(addr, MULTI);

  // bit_cnt counts completed SCK rises, so it reaches TOTAL_BITS during the
  // final high half-period.
  assign last_bit = (bit_cnt == BIT_LAST);

  // The first fall leaves SETUP with MOSI already showing cmd[7]; only the
  // falls inside XFER advance the command shifter.
  assign tx_shift = fall && (state == XFER);

`ifdef SPI_LATE_SAMPLE_EN
  // End of every high half in XFER: the fall that starts the next bit, or
  // the XFER->HOLD edge after the last bit.
  assign sample = high_end && (state == XFER);
`else
  assign sample = rise;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)                state_next = SETUP;
      SETUP:   if (tick)                 state_next = XFER;
      XFER:    if (high_end && last_bit) state_next = HOLD;
      HOLD:    if (tick)                 state_next = DONE;
      DONE:                              state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    load    = 1'b0;
    finish  = 1'b0;
    sck_en  = 1'b0;
    sck_run = 1'b0;
    unique case (state)
      IDLE:  load = start;
      SETUP: begin
        sck_en  = 1'b1;
        sck_run = 1'b1;
      end
      XFER: begin
        sck_en  = 1'b1;
        sck_run = !last_bit;
      end
      HOLD:  sck_en = 1'b1;
      DONE:  finish = 1'b1;
      default: begin
        load    = 1'b0;
        finish  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      CS      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      data    <= '0;
      MOSI    <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;

      if (load) begin
        CS      <= 1'b0;
        busy    <= 1'b1;
        MOSI    <= cmd_word[CMD_READ_BIT];
        tx_sr   <= cmd_word[6:0];
        bit_cnt <= '0;
      end

      // Zero fill: MOSI stays low once the command byte has been sent.
      if (tx_shift) begin
        MOSI  <= tx_sr[6];
        tx_sr <= {tx_sr[5:0], 1'b0};
      end

      if (rise) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end

      // The register is exactly DATA_W wide, so the command-phase MISO bits
      // are pushed out of the top by the data bits that follow them.
      if (sample) begin
        rx_sr <= {rx_sr[DATA_W-2:0], MISO};
      end

      if (finish) begin
        CS   <= 1'b1;
        busy <= 1'b0;
        done <= 1'b1;
        data <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// -----------------------------------------------------------------------------
// tb_accel_spi_reader
// Three reader instances share clk/rst/addr:
//   a: CLK_DIV=4, NUM_BYTES=6  main burst, ignored starts, reset, back-to-back
//   b: CLK_DIV=1, NUM_BYTES=1  minimum configuration
//   c: CLK_DIV=2, NUM_BYTES=2  slave that updates MISO on SCK rise
// Slaves a/b are mode-3 slaves (MISO changes on SCK fall). Each slave indexes
// its bit stream by SCK edges counted since the bench's per-burst snapshot.
// -----------------------------------------------------------------------------
module tb_accel_spi_reader;

  localparam int CD_A  = 4;
  localparam int NB_A  = 6;
  localparam int TB_A  = 8 + 8 * NB_A;
  localparam int LAT_A = 1 + CD_A * (2 * TB_A + 2);

  localparam int CD_B  = 1;
  localparam int NB_B  = 1;
  localparam int TB_B  = 8 + 8 * NB_B;
  localparam int LAT_B = 1 + CD_B * (2 * TB_B + 2);

  localparam int CD_C  = 2;
  localparam int NB_C  = 2;
  localparam int TB_C  = 8 + 8 * NB_C;
  localparam int LAT_C = 1 + CD_C * (2 * TB_C + 2);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] addr = '0;

  logic st_a = 1'b0, busy_a, done_a, sck_a, mosi_a, cs_a;
  logic st_b = 1'b0, busy_b, done_b, sck_b, mosi_b, cs_b;
  logic st_c = 1'b0, busy_c, done_c, sck_c, mosi_c, cs_c;
  logic miso_a = 1'b0, miso_b = 1'b0, miso_c = 1'b0;
  logic [8*NB_A-1:0] data_a;
  logic [8*NB_B-1:0] data_b;
  logic [8*NB_C-1:0] data_c;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  accel_spi_reader #(.CLK_DIV(CD_A), .NUM_BYTES(NB_A)) dut_a (
    .clk(clk), .rst(rst), .start(st_a), .addr(addr), .busy(busy_a), .done(done_a),
    .data(data_a), .SCK(sck_a), .MOSI(mosi_a), .MISO(miso_a), .CS(cs_a));

  accel_spi_reader #(.CLK_DIV(CD_B), .NUM_BYTES(NB_B)) dut_b (
    .clk(clk), .rst(rst), .start(st_b), .addr(addr), .busy(busy_b), .done(done_b),
    .data(data_b), .SCK(sck_b), .MOSI(mosi_b), .MISO(miso_b), .CS(cs_b));

  accel_spi_reader #(.CLK_DIV(CD_C), .NUM_BYTES(NB_C)) dut_c (
    .clk(clk), .rst(rst), .start(st_c), .addr(addr), .busy(busy_c), .done(done_c),
    .data(data_c), .SCK(sck_c), .MOSI(mosi_c), .MISO(miso_c), .CS(cs_c));

  // ---------------------------------------------------------------------------
  // Slave models and SCK/MOSI monitors
  // ---------------------------------------------------------------------------
  logic [TB_A-1:0] stream_a = '0;
  logic [TB_B-1:0] stream_b = '0;
  logic [TB_C-1:0] stream_c = '0;
  int fall_total_a = 0, fall_base_a = 0, rise_total_a = 0, rise_base_a = 0;
  int fall_total_b = 0, fall_base_b = 0, rise_total_b = 0, rise_base_b = 0;
  int rise_total_c = 0, rise_base_c = 0;
  logic [63:0] mosi_log_a = '0;
  logic [63:0] mosi_log_b = '0;

  always @(negedge sck_a) begin
    int k;
    k = fall_total_a - fall_base_a;
    if (!cs_a) miso_a = (k >= 0 && k < TB_A) ? stream_a[TB_A-1-k] : 1'b0;
    fall_total_a++;
  end

  always @(posedge sck_a) begin
    mosi_log_a = {mosi_log_a[62:0], mosi_a};
    rise_total_a++;
  end

  always @(negedge sck_b) begin
    int k;
    k = fall_total_b - fall_base_b;
    if (!cs_b) miso_b = (k >= 0 && k < TB_B) ? stream_b[TB_B-1-k] : 1'b0;
    fall_total_b++;
  end

  always @(posedge sck_b) begin
    mosi_log_b = {mosi_log_b[62:0], mosi_b};
    rise_total_b++;
  end

  // Slave c presents bit k right after the k-th SCK rise.
  always @(posedge sck_c) begin
    int k;
    k = rise_total_c - rise_base_c;
    if (!cs_c) miso_c = (k >= 0 && k < TB_C) ? stream_c[TB_C-1-k] : 1'b0;
    rise_total_c++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  function automatic logic done_of(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // One-cycle start pulse; returns at the negedge right after the accepting edge.
  task automatic kick(input int which, input logic [5:0] a);
    addr = a;
    fall_base_a = fall_total_a; rise_base_a = rise_total_a;
    fall_base_b = fall_total_b; rise_base_b = rise_total_b;
    rise_base_c = rise_total_c;
    @(negedge clk);
    case (which)
      0:       st_a = 1'b1;
      1:       st_b = 1'b1;
      default: st_c = 1'b1;
    endcase
    @(negedge clk);
    st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
  endtask

  // Counts clk cycles until done; n == bound means it never came.
  task automatic wait_done(input int which, input int bound, output int n);
    n = 0;
    while (n < bound && done_of(which) !== 1'b1) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (sck_a !== 1'b1)  $display("FAIL reset_sck: got %b want 1", sck_a); else passed++;
    total++; if (cs_a !== 1'b1)   $display("FAIL reset_cs: got %b want 1", cs_a); else passed++;
    total++; if (mosi_a !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
    total++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else passed++;
    total++; if (data_a !== '0)   $display("FAIL reset_data: got %h want 0", data_a); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst;
    int n;
    stream_a = {8'h00, 48'h010203040506};
    kick(0, 6'h32);
    total++; if (busy_a !== 1'b1 || cs_a !== 1'b0)
      $display("FAIL burst_start: busy=%b cs=%b want busy=1 cs=0", busy_a, cs_a); else passed++;
    wait_done(0, LAT_A + 50, n);
    total++; if (n !== LAT_A) $display("FAIL burst_latency: got %0d want %0d", n, LAT_A); else passed++;
    total++; if (data_a !== 48'h010203040506)
      $display("FAIL burst_data: got %h want 010203040506", data_a); else passed++;
    total++; if (mosi_log_a[TB_A-1 -: 8] !== 8'hF2)
      $display("FAIL burst_cmd: got %h want f2", mosi_log_a[TB_A-1 -: 8]); else passed++;
    total++; if (rise_total_a - rise_base_a !== TB_A)
      $display("FAIL burst_rises: got %0d want %0d", rise_total_a - rise_base_a, TB_A); else passed++;
    total++; if (cs_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL burst_end: cs=%b busy=%b want cs=1 busy=0", cs_a, busy_a); else passed++;
    @(negedge clk);
    total++; if (done_a !== 1'b0) $display("FAIL burst_done_width: got %b want 0", done_a); else passed++;
    total++; if (data_a !== 48'h010203040506)
      $display("FAIL burst_data_hold: got %h want 010203040506", data_a); else passed++;
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    int first = -1;
    stream_a = {8'h00, 48'hA1B2C3D4E5F6};
    kick(0, 6'h32);
    for (int n = 1; n <= LAT_A + 60; n++) begin
      @(negedge clk);
      // Pulses while busy, and in the DONE-state cycle, plus an addr change.
      st_a = (n == 10 || n == 200 || n == LAT_A - 1);
      if (n == 10) addr = 6'h0F;
      if (n == 100) begin
        total++; if (data_a !== 48'h010203040506)
          $display("FAIL ignore_data_hold: got %h want 010203040506", data_a); else passed++;
      end
      if (done_a === 1'b1) begin
        dones++;
        if (first < 0) first = n;
      end
    end
    st_a = 1'b0;
    total++; if (dones !== 1) $display("FAIL ignore_done_count: got %0d want 1", dones); else passed++;
    total++; if (first !== LAT_A) $display("FAIL ignore_latency: got %0d want %0d", first, LAT_A); else passed++;
    total++; if (data_a !== 48'hA1B2C3D4E5F6)
      $display("FAIL ignore_data: got %h want a1b2c3d4e5f6", data_a); else passed++;
    total++; if (mosi_log_a[TB_A-1 -: 8] !== 8'hF2)
      $display("FAIL ignore_cmd: got %h want f2", mosi_log_a[TB_A-1 -: 8]); else passed++;
    total++; if (busy_a !== 1'b0 || cs_a !== 1'b1)
      $display("FAIL ignore_idle: busy=%b cs=%b want busy=0 cs=1", busy_a, cs_a); else passed++;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    int dones = 0;
    stream_a = {8'h00, 48'h111111111111};
    kick(0, 6'h10);
    while (rise_total_a - rise_base_a < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++; if (rise_total_a - rise_base_a !== 20)
      $display("FAIL mid_reach_bit20: got %0d rises want 20", rise_total_a - rise_base_a); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (cs_a !== 1'b1 || sck_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL mid_reset: cs=%b sck=%b busy=%b want 1 1 0", cs_a, sck_a, busy_a); else passed++;
    total++; if (data_a !== '0) $display("FAIL mid_reset_data: got %h want 0", data_a); else passed++;
    repeat (LAT_A + 20) begin
      @(negedge clk);
      if (done_a === 1'b1) dones++;
    end
    total++; if (dones !== 0) $display("FAIL mid_no_done: got %0d pulses want 0", dones); else passed++;
    stream_a = {8'h00, 48'h0A0B0C0D0E0F};
    kick(0, 6'h20);
    wait_done(0, LAT_A + 50, n);
    total++; if (n !== LAT_A) $display("FAIL mid_fresh_latency: got %0d want %0d", n, LAT_A); else passed++;
    total++; if (data_a !== 48'h0A0B0C0D0E0F)
      $display("FAIL mid_fresh_data: got %h want 0a0b0c0d0e0f", data_a); else passed++;
    total++; if (mosi_log_a[TB_A-1 -: 8] !== 8'hE0)
      $display("FAIL mid_fresh_cmd: got %h want e0", mosi_log_a[TB_A-1 -: 8]); else passed++;
  endtask

  task automatic test_back_to_back;
    int n1;
    int n2;
    stream_a = {8'h00, 48'hCAFEF00D1234};
    addr = 6'h32;
    fall_base_a = fall_total_a; rise_base_a = rise_total_a;
    @(negedge clk);
    st_a = 1'b1;
    @(negedge clk);
    wait_done(0, LAT_A + 50, n1);
    total++; if (n1 !== LAT_A) $display("FAIL b2b_latency1: got %0d want %0d", n1, LAT_A); else passed++;
    total++; if (data_a !== 48'hCAFEF00D1234 || cs_a !== 1'b1)
      $display("FAIL b2b_first: data=%h cs=%b want cafef00d1234 1", data_a, cs_a); else passed++;
    stream_a = {8'h00, 48'h13579BDF0246};
    fall_base_a = fall_total_a; rise_base_a = rise_total_a;
    @(negedge clk);
    total++; if (cs_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL b2b_restart: cs=%b busy=%b want 0 1", cs_a, busy_a); else passed++;
    wait_done(0, LAT_A + 50, n2);
    st_a = 1'b0;
    total++; if (n2 !== LAT_A) $display("FAIL b2b_latency2: got %0d want %0d", n2, LAT_A); else passed++;
    total++; if (data_a !== 48'h13579BDF0246)
      $display("FAIL b2b_data2: got %h want 13579bdf0246", data_a); else passed++;
    @(negedge clk);
    total++; if (busy_a !== 1'b0) $display("FAIL b2b_stop: busy=%b want 0", busy_a); else passed++;
  endtask

  task automatic test_min_config;
    int n;
    stream_b = {8'h00, 8'hE5};
    kick(1, 6'h00);
    wait_done(1, LAT_B + 50, n);
    total++; if (n !== 35) $display("FAIL min_latency: got %0d want 35", n); else passed++;
    total++; if (data_b !== 8'hE5) $display("FAIL min_data: got %h want e5", data_b); else passed++;
    total++; if (mosi_log_b[TB_B-1 -: 8] !== 8'h80)
      $display("FAIL min_cmd: got %h want 80", mosi_log_b[TB_B-1 -: 8]); else passed++;
    total++; if (rise_total_b - rise_base_b !== 16)
      $display("FAIL min_rises: got %0d want 16", rise_total_b - rise_base_b); else passed++;
  endtask

  task automatic test_late_sample;
    int n;
    logic [15:0] expect_c;
`ifdef SPI_LATE_SAMPLE_EN
    expect_c = 16'hA55A;
`else
    // Sampling on the rise catches the previous bit: a one-bit right shift
    // with the last command-phase bit (0) entering at the top.
    expect_c = 16'h52AD;
`endif
    stream_c = {8'h00, 16'hA55A};
    kick(2, 6'h01);
    wait_done(2, LAT_C + 50, n);
    total++; if (n !== LAT_C) $display("FAIL late_latency: got %0d want %0d", n, LAT_C); else passed++;
    total++; if (data_c !== expect_c) $display("FAIL late_data: got %h want %h", data_c, expect_c); else passed++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_min_config();
    test_late_sample();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
